// File: rtl/ignition_sequencer.sv
// Engine-start sequencer: key entry over valid/ready, compare, timed run/error/lockout.
// Optional runtime key programming is enabled by defining IGNITION_KEY_PROG_EN.
module ignition_sequencer #(
    parameter int unsigned               KEY_LEN     = 3,
    parameter logic [4*KEY_LEN-1:0]      TRUE_KEY    = 12'h5A3,
    parameter int unsigned               MAX_TRIES   = 3,
    parameter int unsigned               RUN_CYCLES  = 8,
    parameter int unsigned               ERR_CYCLES  = 4,
    parameter int unsigned               LOCK_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_req,
    input  logic                   abort,
    input  logic                   digit_valid,
    input  logic [3:0]             digit,
`ifdef IGNITION_KEY_PROG_EN
    input  logic                   prog_valid,
    input  logic [4*KEY_LEN-1:0]   prog_key,
`endif
    output logic                   digit_ready,
    output logic                   engine_on,
    output logic                   locked,
    output logic [1:0]             tries_left,
    output logic [2:0]             disp_code,
    output logic [2:0]             led
);

    localparam int unsigned KW    = 4 * KEY_LEN;
    localparam int unsigned MAX_A = (RUN_CYCLES > ERR_CYCLES) ? RUN_CYCLES : ERR_CYCLES;
    localparam int unsigned MAXC  = (MAX_A > LOCK_CYCLES) ? MAX_A : LOCK_CYCLES;
    localparam int unsigned TW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned IW    = $clog2(KEY_LEN + 1);
    localparam logic [1:0]  MAXT  = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTER = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_fail;
    logic [TW-1:0]   r_timer;
    logic [IW-1:0]   r_idx;
    logic [KW-1:0]   r_buf;
    logic            r_digit_ready;
    logic            r_engine_on;
    logic            r_locked;
    logic [1:0]      r_tries;
    logic [2:0]      r_disp;
    logic [2:0]      r_led;
    logic [KW-1:0]   w_key;

`ifdef IGNITION_KEY_PROG_EN
    logic [KW-1:0]   r_key;
    logic            r_prog_flag;
    assign w_key = r_key;
`else
    assign w_key = TRUE_KEY;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fail        <= '0;
            r_timer       <= '0;
            r_idx         <= '0;
            r_buf         <= '0;
            r_digit_ready <= 1'b0;
            r_engine_on   <= 1'b0;
            r_locked      <= 1'b0;
            r_tries       <= MAXT;
            r_disp        <= 3'b000;
            r_led         <= 3'd0;
`ifdef IGNITION_KEY_PROG_EN
            r_key         <= TRUE_KEY;
            r_prog_flag   <= 1'b0;
`endif
        end else begin
            // Outputs are decoded from the state held during this cycle, so they trail it by one edge
            r_digit_ready <= (r_state == S_ENTER);
            r_engine_on   <= (r_state == S_RUN);
            r_locked      <= (r_state == S_LOCK);
            r_tries       <= MAXT - r_fail;
            r_led         <= r_state;
            case (r_state)
                S_ENTER: r_disp <= 3'b001;
                S_CHECK: r_disp <= 3'b011;
                S_RUN:   r_disp <= 3'b101;
                S_ERROR: r_disp <= 3'b110;
                S_LOCK:  r_disp <= 3'b111;
                default: r_disp <= 3'b000;
            endcase
`ifdef IGNITION_KEY_PROG_EN
            r_prog_flag <= 1'b0;
            if (r_prog_flag) r_disp <= 3'b010;
`endif

            case (r_state)
                S_IDLE: begin
                    if (start_req) begin
                        r_state <= S_ENTER;
                        r_idx   <= '0;
                        r_buf   <= '0;
                    end
`ifdef IGNITION_KEY_PROG_EN
                    if (prog_valid) begin
                        r_key       <= prog_key;
                        r_fail      <= '0;
                        r_prog_flag <= 1'b1;
                    end
`endif
                end
                S_ENTER: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_buf   <= '0;
                    end else if (digit_valid && r_digit_ready) begin
                        r_buf[{r_idx, 2'b00} +: 4] <= digit;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IW'(KEY_LEN - 1)) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_buf == w_key) begin
                        r_fail  <= '0;
                        r_timer <= TW'(RUN_CYCLES - 1);
                        r_state <= S_RUN;
                    end else begin
                        r_fail <= r_fail + 2'd1;
                        if (r_fail + 2'd1 == MAXT) begin
                            r_timer <= TW'(LOCK_CYCLES - 1);
                            r_state <= S_LOCK;
                        end else begin
                            r_timer <= TW'(ERR_CYCLES - 1);
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_buf   <= '0;
                    end else if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_ERROR: begin
                    if (r_timer == '0) r_state <= S_IDLE;
                    else               r_timer <= r_timer - 1'b1;
                end
                S_LOCK: begin
                    if (r_timer == '0) begin
                        r_fail  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign digit_ready = r_digit_ready;
    assign engine_on   = r_engine_on;
    assign locked      = r_locked;
    assign tries_left  = r_tries;
    assign disp_code   = r_disp;
    assign led         = r_led;

endmodule

// File: tb/tb_ignition_sequencer.sv
// Directed bench for ignition_sequencer: good key, failure, lockout, stall, abort, mid-run reset.
module tb_ignition_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_req = 1'b0;
    logic       abort = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_ready;
    logic       engine_on;
    logic       locked;
    logic [1:0] tries_left;
    logic [2:0] disp_code;
    logic [2:0] led;

    int checks = 0;
    int failures = 0;

    int          eng_cnt, lock_cnt, err_cnt, chk_cnt;
    logic [23:0] hist;
    logic [2:0]  last_disp;

    ignition_sequencer #(
        .KEY_LEN     (3),
        .TRUE_KEY    (12'h5A3),
        .MAX_TRIES   (3),
        .RUN_CYCLES  (8),
        .ERR_CYCLES  (4),
        .LOCK_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_req   (start_req),
        .abort       (abort),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .engine_on   (engine_on),
        .locked      (locked),
        .tries_left  (tries_left),
        .disp_code   (disp_code),
        .led         (led)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        eng_cnt   = 0;
        lock_cnt  = 0;
        err_cnt   = 0;
        chk_cnt   = 0;
        hist      = '0;
        last_disp = disp_code;
    endtask

    // One clock edge, then sample outputs 1 time unit later and update the monitor
    task automatic tick();
        @(posedge clock);
        #1;
        if (engine_on) eng_cnt++;
        if (locked) lock_cnt++;
        if (disp_code == 3'b110) err_cnt++;
        if (disp_code == 3'b011) chk_cnt++;
        if (disp_code != last_disp) begin
            hist      = {hist[20:0], disp_code};
            last_disp = disp_code;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic enter_key(input logic [11:0] key, input logic abort_last);
        logic acc;
        logic done;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            digit       = key[4*k +: 4];
            digit_valid = 1'b1;
            if (k == 2) abort = abort_last;
            done = 1'b0;
            for (int n = 0; n < 10 && !done; n++) begin
                acc = digit_ready;
                tick();
                done = acc;
            end
            if (!done) check("ready_timeout", 0, 1);
        end
        digit_valid = 1'b0;
        abort       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_engine", engine_on, 0);
        check("rst_locked", locked, 0);
        check("rst_ready", digit_ready, 0);
        check("rst_tries", tries_left, 3);
        check("rst_disp", disp_code, 0);
        check("rst_led", led, 0);

        // Good key 3,A,5
        clear_mon();
        enter_key(12'h5A3, 1'b0);
        tick();
        check("good_led_check", led, 2);
        check("good_disp_check", disp_code, 3'b011);
        idle(20);
        check("good_eng_cycles", eng_cnt, 8);
        check("good_disp_seq", int'(hist), int'(24'o1350));
        check("good_tries", tries_left, 3);
        check("good_engine_off", engine_on, 0);

        // Single failure
        clear_mon();
        enter_key(12'h321, 1'b0);
        idle(20);
        check("fail_err_cycles", err_cnt, 4);
        check("fail_disp_seq", int'(hist), int'(24'o1360));
        check("fail_tries", tries_left, 2);
        check("fail_led_idle", led, 0);

        // Lockout after three consecutive failures
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_mon();
        enter_key(12'h321, 1'b0);
        idle(8);
        check("lock_tries_after1", tries_left, 2);
        enter_key(12'h321, 1'b0);
        idle(8);
        check("lock_tries_after2", tries_left, 1);
        enter_key(12'h321, 1'b0);
        tick();
        tick();
        check("lock_locked", locked, 1);
        check("lock_tries_zero", tries_left, 0);
        start_req = 1'b1;
        abort     = 1'b1;
        tick();
        start_req = 1'b0;
        abort     = 1'b0;
        idle(30);
        check("lock_cycles", lock_cnt, 16);
        check("lock_led_idle", led, 0);
        check("lock_start_ignored", digit_ready, 0);
        check("lock_tries_restored", tries_left, 3);

        // Handshake stall: valid pattern 1,0,0,1,1; junk digit 7 while valid low
        clear_mon();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        check("stall_ready", digit_ready, 1);
        digit = 4'h3; digit_valid = 1'b1; tick();
        digit = 4'h7; digit_valid = 1'b0; tick();
        tick();
        digit = 4'hA; digit_valid = 1'b1; tick();
        digit = 4'h5; digit_valid = 1'b1; tick();
        digit_valid = 1'b0;
        check("stall_still_enter", led, 1);
        tick();
        check("stall_check", led, 2);
        idle(20);
        check("stall_eng_cycles", eng_cnt, 8);

        // Abort together with the third digit
        clear_mon();
        enter_key(12'h5A3, 1'b1);
        tick();
        check("abort_dig_led", led, 0);
        idle(10);
        check("abort_dig_no_check", chk_cnt, 0);
        check("abort_dig_no_run", eng_cnt, 0);
        check("abort_dig_tries", tries_left, 3);

        // Abort on the second RUN cycle
        clear_mon();
        enter_key(12'h5A3, 1'b0);
        tick();
        tick();
        check("abort_run_on", engine_on, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_run_off", engine_on, 0);
        idle(15);
        check("abort_run_cycles", eng_cnt, 2);

        // Reset during RUN, then a normal start
        enter_key(12'h5A3, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_engine", engine_on, 0);
        check("midrst_led", led, 0);
        check("midrst_disp", disp_code, 0);
        check("midrst_tries", tries_left, 3);
        check("midrst_ready", digit_ready, 0);
        clear_mon();
        enter_key(12'h5A3, 1'b0);
        idle(20);
        check("midrst_restart", eng_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ignition_sequencer.md
Name: ignition_sequencer

Overview:
- Controller that sequences the engine-start path: collects a multi-digit key over a valid/ready handshake and checks it against the stored key.
- On a match, enables the engine for a timed run window. On a mismatch, shows an error and counts failed attempts.
- Enters a timed lockout after MAX_TRIES consecutive failures.
- Sits between the keypad front-end and the engine-enable / 7-segment display logic; supplies display codes and status LEDs.

Parameters:
- KEY_LEN, 3: number of 4-bit digits per key (1..4).
- TRUE_KEY, 12'h5A3: reset value of the stored key, 4*KEY_LEN bits; digit 0 in the LSBs.
- MAX_TRIES, 3: consecutive failures before lockout (1..3).
- RUN_CYCLES, 8: cycles engine_on stays high per successful start (>=1).
- ERR_CYCLES, 4: cycles spent in ERROR (>=1).
- LOCK_CYCLES, 16: cycles spent in LOCK (>=1).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start_req  in  1  1-cycle pulse requesting key entry.
- abort  in  1  cancels entry or run; returns to IDLE next cycle.
- digit_valid  in  1  digit present.
- digit  in  4  key digit.
- digit_ready  out  1  high only in ENTER.
- engine_on  out  1  high only in RUN.
- locked  out  1  high only in LOCK.
- tries_left  out  2  MAX_TRIES minus failure count.
- disp_code  out  3  display symbol: 000 blank, 001 U, 010 P, 011 C, 100 H, 101 F, 110 A, 111 L.
- led  out  3  current state encoding.

Behaviour:
- Reset (sync, highest priority): state=IDLE, engine_on=0, locked=0, digit_ready=0, fail count=0, tries_left=MAX_TRIES, disp_code=000, digit index=0, timer=0, stored key=TRUE_KEY.
- State encoding: IDLE=0, ENTER=1, CHECK=2, RUN=3, ERROR=4, LOCK=5.
- All outputs are registered and decoded from the registered state, so an output changes the cycle after its state transition.
- IDLE:
  - disp=000.
  - start_req -> ENTER; digit index and entry buffer cleared.
- ENTER:
  - disp=001 (U); digit_ready=1.
  - A digit is accepted on a cycle where digit_valid && digit_ready. It is written to buffer[index], and index increments.
  - After the KEY_LEN-th accept -> CHECK.
  - digit_valid with no start_req is ignored outside ENTER.
  - No timeout.
- CHECK:
  - Exactly 1 cycle; disp=011 (C).
  - If buffer==stored key: fail count=0, timer=RUN_CYCLES-1, -> RUN.
  - Otherwise: fail count+1.
    - If the new count==MAX_TRIES: timer=LOCK_CYCLES-1, -> LOCK.
    - Else: timer=ERR_CYCLES-1, -> ERROR.
- RUN:
  - disp=101 (F); engine_on=1.
  - Timer decrements each cycle; at timer==0 -> IDLE.
  - engine_on is high for exactly RUN_CYCLES cycles.
- ERROR:
  - disp=110 (A).
  - Timer decrements; at 0 -> IDLE (not directly to ENTER).
- LOCK:
  - disp=111 (L); locked=1.
  - start_req and abort are ignored.
  - At timer==0: fail count=0, -> IDLE.
- abort:
  - Honoured in ENTER and RUN only; next state is IDLE.
  - Entry buffer discarded; fail count unchanged.
  - Takes priority over a simultaneous digit accept or timer expiry.
- start_req outside IDLE is ignored; it is not queued.
- tries_left is MAX_TRIES minus fail count and saturates at 0 in LOCK.
- Widths:
  - Timer width = clog2 of max(RUN,ERR,LOCK)_CYCLES.
  - Index width = clog2(KEY_LEN+1).
  - No arithmetic overflow is possible given the parameter ranges.
- Mid-operation reset: any state -> IDLE next edge; engine_on drops that edge.

Optional Feature:
- Macro: IGNITION_KEY_PROG_EN.
- When defined:
  - Adds inputs prog_valid (1) and prog_key (4*KEY_LEN).
  - prog_valid in IDLE loads prog_key into the stored key on that edge; it is ignored in every other state.
  - disp shows 010 (P) for one cycle after the load.
  - Loading also clears the fail count.
- When undefined:
  - The ports are absent.
  - The stored key is constant TRUE_KEY.

Test Plan:
- Good key: reset, start_req, digits 3,A,5 with valid each cycle -> CHECK on cycle 4; engine_on high exactly 8 cycles; disp sequence 001,011,101,000; tries_left=3.
- Single failure: digits 1,2,3 -> ERROR for 4 cycles with disp=110, then IDLE; tries_left=2.
- Lockout: three bad entries back-to-back -> LOCK; locked=1 for 16 cycles; start_req during LOCK ignored; afterward tries_left=3.
- Handshake stall: digit_valid toggled 1,0,0,1,1 -> exactly 3 digits captured; no capture while valid low.
- Abort/priority: abort on the same cycle as the 3rd digit -> IDLE, no CHECK. abort on the 2nd RUN cycle -> engine_on low next edge.
- Reset mid-RUN: reset high one cycle -> all outputs at reset values on the next edge; a subsequent good key starts normally.
